// File: rtl/sort_stream_adapter.sv
// -----------------------------------------------------------------------------
// sort_stream_adapter
//
// Initiator-side controller for a packed-vector sorter. It collects N elements
// from an input stream into slots 0..N-1, presents the packed batch to the
// sorter with a one-cycle start pulse, and waits for a rising edge on
// sort_done. It then captures the sorted word and streams it out in slot order.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid && ready are both high. A producer keeps valid and its data
// stable until that transfer. Ready may change freely.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_data    input element stream
//   in_ready            high only while filling a batch
//   sort_start          one-cycle start pulse to the sorter
//   sort_data_in        packed batch, slot i at [i*W +: W]
//   sort_data_out       sorted packed word returned by the sorter
//   sort_done           sorter completion level; only its rising edge counts
//   out_valid/out_data  output element stream, slot 0 first
//   out_ready           downstream accept
//   out_last            marks slot N-1 of the batch
//   busy                high in every state other than FILL
//   err                 one-cycle pulse when the wait for the sorter times out
//   state_dbg           current FSM state (0 FILL, 1 START, 2 WAIT, 3 DRAIN)
// -----------------------------------------------------------------------------
module sort_stream_adapter #(
   parameter int N       = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   input  logic [W-1:0]   in_data,
   output logic           in_ready,
   output logic           sort_start,
   output logic [N*W-1:0] sort_data_in,
   input  logic [N*W-1:0] sort_data_out,
   input  logic           sort_done,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   input  logic           out_ready,
   output logic           out_last,
   output logic           busy,
   output logic           err,
   output logic [1:0]     state_dbg
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_MAX = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    slot_q [N];
   logic            done_q;
   logic [TW-1:0]   timer_q;

   logic            rise;
   logic            timeout_hit;
   logic            capture;
   logic            clear_slots;

   // done_q resets high so a done level left over from a previous run is
   // never mistaken for completion; only a fresh 0->1 edge counts.
   assign rise        = sort_done & ~done_q;
   assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMER_MAX);

   assign out_data  = slot_q[cnt_q];
   assign state_dbg = state_q;

   // The slots drive the sorter continuously; they only change in FILL and
   // on leaving WAIT, so the word is stable for the whole sort.
   always_comb begin
      sort_data_in = '0;
      for (int i = 0; i < N; i++) begin
         sort_data_in[i*W +: W] = slot_q[i];
      end
   end

   // Next state and outputs
   always_comb begin
      state_d     = state_q;
      in_ready    = 1'b0;
      sort_start  = 1'b0;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      busy        = 1'b1;
      err         = 1'b0;
      capture     = 1'b0;
      clear_slots = 1'b0;
      unique case (state_q)
         S_FILL: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid && (cnt_q == CNT_MAX)) begin
               state_d = S_START;
            end
         end
         S_START: begin
            sort_start = 1'b1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            // A completion edge wins over a timeout landing in the same cycle.
            if (rise) begin
               capture = 1'b1;
               state_d = S_DRAIN;
            end else if (timeout_hit) begin
               err         = 1'b1;
               clear_slots = 1'b1;
               state_d     = S_FILL;
            end
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            out_last  = (cnt_q == CNT_MAX);
            if (out_ready && (cnt_q == CNT_MAX)) begin
               state_d = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FILL;
         cnt_q   <= '0;
         done_q  <= 1'b1;
         timer_q <= '0;
         for (int i = 0; i < N; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         done_q  <= sort_done;
         unique case (state_q)
            S_FILL: begin
               if (in_valid) begin
                  slot_q[cnt_q] <= in_data;
                  cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
               end
            end
            S_START: begin
               timer_q <= '0;
            end
            S_WAIT: begin
               if (capture) begin
                  for (int i = 0; i < N; i++) begin
                     slot_q[i] <= sort_data_out[i*W +: W];
                  end
                  cnt_q <= '0;
               end else if (clear_slots) begin
                  for (int i = 0; i < N; i++) begin
                     slot_q[i] <= '0;
                  end
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
